// File: rtl/img_pkg.sv
// Shared defaults and state encoding for the image feed controller.
package img_pkg;

    localparam int unsigned INTEGER_BITS     = 8;
    localparam int unsigned FIXED_POINT_BITS = 4;
    localparam int unsigned IMG_WIDTH        = 512;
    localparam int unsigned IMG_HEIGHT       = 512;
    localparam int unsigned NUM_LINE_BUFFERS = 4;

    localparam int unsigned PIXEL_W = INTEGER_BITS + FIXED_POINT_BITS;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFeed  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/line_credit_counter.sv
// Tracks free downstream line buffers and returned-line interrupts for one frame.
module line_credit_counter #(
    parameter int unsigned NUM_LINE_BUFFERS = img_pkg::NUM_LINE_BUFFERS,
    parameter int unsigned IMG_HEIGHT       = img_pkg::IMG_HEIGHT
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_load,
    input  logic                                  i_active,
    input  logic                                  i_line_done,
    input  logic                                  i_intr,
    output logic [$clog2(NUM_LINE_BUFFERS+1)-1:0] o_credits,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]       o_intr_cnt_next,
    output logic                                  o_err
);
    localparam int unsigned CredW = $clog2(NUM_LINE_BUFFERS + 1);
    localparam int unsigned CntW  = $clog2(IMG_HEIGHT + 1);
    localparam logic [CredW-1:0] FullCredits = CredW'(NUM_LINE_BUFFERS);

    logic [CredW-1:0] credits_q, credits_d;
    logic [CntW-1:0]  intr_cnt_q, intr_cnt_d;
    logic             err_q, err_d;
    logic             intr_take;

    always_comb begin
        credits_d  = credits_q;
        intr_cnt_d = intr_cnt_q;
        err_d      = err_q;
        intr_take  = i_active && i_intr;
        if (i_load) begin
            credits_d  = FullCredits;
            intr_cnt_d = '0;
        end else begin
            if (intr_take && (intr_cnt_q != '1)) begin
                intr_cnt_d = intr_cnt_q + 1'b1;
            end
            // A returned buffer and a consumed one in the same beat cancel out.
            if (intr_take && !i_line_done) begin
                if (credits_q == FullCredits) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + 1'b1;
                end
            end else if (!intr_take && i_line_done && (credits_q != '0)) begin
                credits_d = credits_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q  <= '0;
            intr_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            intr_cnt_q <= intr_cnt_d;
            err_q      <= err_d;
        end
    end

    assign o_credits       = credits_q;
    assign o_intr_cnt_next = intr_cnt_d;
    assign o_err           = err_q;

endmodule

// File: rtl/image_feed_ctrl.sv
// Feeds upstream pixels to the window generator, throttled by free line buffers.
module image_feed_ctrl #(
    parameter int unsigned INTEGER_BITS     = img_pkg::INTEGER_BITS,
    parameter int unsigned FIXED_POINT_BITS = img_pkg::FIXED_POINT_BITS,
    parameter int unsigned IMG_WIDTH        = img_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT       = img_pkg::IMG_HEIGHT,
    parameter int unsigned NUM_LINE_BUFFERS = img_pkg::NUM_LINE_BUFFERS,
    localparam int unsigned PW = INTEGER_BITS + FIXED_POINT_BITS
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [PW-1:0] i_s_data,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    output logic [PW-1:0] o_pixel_data,
    output logic          o_pixel_data_valid,
    input  logic          i_intr,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_err
);
    import img_pkg::*;

    localparam int unsigned ColW  = $clog2(IMG_WIDTH);
    localparam int unsigned RowW  = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned CredW = $clog2(NUM_LINE_BUFFERS + 1);

    localparam logic [ColW-1:0] ColLast     = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast     = RowW'(IMG_HEIGHT - 1);
    localparam logic [RowW-1:0] DrainTarget = RowW'(IMG_HEIGHT - 2);

    feed_state_e      state_q, state_d;
    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [CredW-1:0] credits;
    logic [RowW-1:0]  intr_cnt_next;
    logic [PW-1:0]    pix_q;
    logic             pix_valid_q;
    logic             frame_start, active, xfer, line_done;

    assign frame_start = (state_q == StIdle) && i_start;
    assign active      = (state_q == StFeed) || (state_q == StDrain);
    assign o_s_ready   = (state_q == StFeed) && (credits != '0);
    assign xfer        = i_s_valid && o_s_ready;
    assign line_done   = xfer && (col_q == ColLast);

    line_credit_counter #(
        .NUM_LINE_BUFFERS(NUM_LINE_BUFFERS),
        .IMG_HEIGHT      (IMG_HEIGHT)
    ) u_credit (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_load         (frame_start),
        .i_active       (active),
        .i_line_done    (line_done),
        .i_intr         (i_intr),
        .o_credits      (credits),
        .o_intr_cnt_next(intr_cnt_next),
        .o_err          (o_err)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StFeed;
            StFeed:  if (line_done && (row_q == RowLast)) state_d = StDrain;
            StDrain: if (intr_cnt_next >= DrainTarget) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (xfer) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_valid_q <= xfer;
            if (xfer) begin
                pix_q <= i_s_data;
            end
        end
    end

    assign o_pixel_data       = pix_q;
    assign o_pixel_data_valid = pix_valid_q;
    assign o_busy             = active;
    assign o_frame_done       = (state_q == StDone);

endmodule

// File: tb/tb_image_feed_ctrl.sv
// Directed bench for image_feed_ctrl with a frame-level reference model.
module tb_image_feed_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned NB = 4;
    localparam int unsigned PW = 12;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          start  = 1'b0;
    logic          s_valid = 1'b0;
    logic          intr   = 1'b0;
    logic [PW-1:0] s_data = 12'h0A5;
    logic          s_ready, pv, busy, fdone, err;
    logic [PW-1:0] pd;

    int total = 0;
    int bad   = 0;
    int pv_seen = 0;
    int fd_seen = 0;
    int base, fd_base;

    always #5 clk = ~clk;

    image_feed_ctrl #(
        .INTEGER_BITS    (8),
        .FIXED_POINT_BITS(4),
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H),
        .NUM_LINE_BUFFERS(NB)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_s_data          (s_data),
        .i_s_valid         (s_valid),
        .o_s_ready         (s_ready),
        .o_pixel_data      (pd),
        .o_pixel_data_valid(pv),
        .i_intr            (intr),
        .o_busy            (busy),
        .o_frame_done      (fdone),
        .o_err             (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: phase 0 idle, 1 feeding, 2 draining, 3 done.
    int            m_phase  = 0;
    int            m_pix    = 0;
    int            m_credit = 0;
    int            m_intr   = 0;
    bit            m_err    = 0;
    bit            m_pv     = 0;
    logic [PW-1:0] m_pd     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_pix <= 0; m_credit <= 0; m_intr <= 0;
            m_err <= 0; m_pv <= 0; m_pd <= '0;
        end else begin : model
            bit xfer, line_end, took;
            int cred;
            xfer     = (m_phase == 1) && (m_credit > 0) && s_valid;
            line_end = xfer && (((m_pix + 1) % W) == 0);
            took     = intr && (m_phase == 1 || m_phase == 2);
            cred     = m_credit - (line_end ? 1 : 0) + (took ? 1 : 0);
            m_pv <= xfer;
            if (xfer) m_pd <= s_data;
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1; m_pix <= 0; m_intr <= 0; m_credit <= NB;
                end
                1, 2: begin
                    if (took) m_intr <= m_intr + 1;
                    if (cred > NB) begin
                        cred = NB;
                        m_err <= 1;
                    end
                    m_credit <= cred;
                    if (xfer) m_pix <= m_pix + 1;
                    if (m_phase == 1 && xfer && (m_pix + 1 == W * H)) m_phase <= 2;
                    if (m_phase == 2 && (m_intr + (took ? 1 : 0) >= H - 2)) m_phase <= 3;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("s_ready", s_ready, (m_phase == 1) && (m_credit > 0));
        check("pix_valid", pv, m_pv);
        check("pix_data", pd, m_pd);
        check("busy", busy, (m_phase == 1) || (m_phase == 2));
        check("frame_done", fdone, m_phase == 3);
        check("err", err, m_err);
        if (pv) pv_seen++;
        if (fdone) fd_seen++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 s_data = s_data + 12'h013;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_intr();
        intr = 1'b1;
        step();
        intr = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        s_valid = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_pv", pv, 0);
        check("rst_busy", busy, 0);

        // Frame A: priming, credit return, full frame.
        step();
        base = pv_seen;
        fd_base = fd_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        @(negedge clk);
        check("prime_count", pv_seen - base, 32);
        check("prime_stall", s_ready, 0);
        base = pv_seen;
        pulse_intr();
        repeat (15) step();
        @(negedge clk);
        check("return_count", pv_seen - base, 8);
        check("return_stall", s_ready, 0);
        base = pv_seen;
        pulse_intr();
        repeat (15) step();
        @(negedge clk);
        check("last_line_count", pv_seen - base, 8);
        check("drain_busy", busy, 1);
        pulse_intr();
        repeat (3) step();
        @(negedge clk);
        check("drain_wait", fdone, 0);
        step();
        intr = 1'b1;
        step();
        intr = 1'b0;
        @(negedge clk);
        check("done_pulse", fdone, 1);
        check("done_busy", busy, 0);
        @(negedge clk);
        check("done_single", fdone, 0);
        check("frame_a_dones", fd_seen - fd_base, 1);

        // Frame B: return coincident with the first line-complete beat.
        step();
        base = pv_seen;
        fd_base = fd_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        intr = 1'b1;
        step();
        intr = 1'b0;
        repeat (45) step();
        @(negedge clk);
        check("collide_count", pv_seen - base, 40);
        check("collide_no_err", err, 0);
        pulse_intr();
        repeat (12) step();
        pulse_intr();
        pulse_intr();
        repeat (4) step();
        @(negedge clk);
        check("frame_b_idle", busy, 0);
        check("frame_b_dones", fd_seen - fd_base, 1);

        // Frame C: return with every buffer already free.
        step();
        s_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        intr = 1'b1;
        step();
        intr = 1'b0;
        @(negedge clk);
        check("overflow_err", err, 1);
        step();
        base = pv_seen;
        s_valid = 1'b1;
        repeat (40) step();
        @(negedge clk);
        check("overflow_sat_count", pv_seen - base, 32);
        check("overflow_sticky", err, 1);

        // Frame D: reset mid-frame, then re-prime.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        base = pv_seen;
        fd_base = fd_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pv_seen - base >= 20) break;
            step();
        end
        check("mid_wait", pv_seen - base >= 20, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pv", pv, 0);
        check("mid_rst_pd", pd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", s_ready, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_done", fdone, 0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_no_done", fd_seen - fd_base, 0);
        base = pv_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        @(negedge clk);
        check("reprime_count", pv_seen - base, 32);
        check("reprime_busy", busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_feed_ctrl.md
IMAGE_FEED_CTRL -- requirements
Module: image_feed_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- INTEGER_BITS, 8, integer bits per pixel.
- FIXED_POINT_BITS, 4, fractional bits per pixel.
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame (>= 3).
- NUM_LINE_BUFFERS, 4, line buffers in the downstream window generator.
REQ-002 The block SHALL use one clock, i_clk; reset SHALL be i_rst_n, asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning), where PW = INTEGER_BITS+FIXED_POINT_BITS:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, async active-low reset.
- i_start, in, 1, one-cycle pulse that starts a frame.
- i_s_data, in, PW, upstream pixel.
- i_s_valid, in, 1, upstream pixel valid.
- o_s_ready, out, 1, upstream ready.
- o_pixel_data, out, PW, pixel to the window generator.
- o_pixel_data_valid, out, 1, pixel write strobe.
- i_intr, in, 1, one-cycle pulse: the window generator finished one output line and freed a buffer.
- o_busy, out, 1, frame in progress.
- o_frame_done, out, 1, one-cycle pulse at frame completion.
- o_err, out, 1, sticky credit-overflow error.

Function
REQ-004 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE.
REQ-005 IDLE -> FEED SHALL occur on i_start; this transition loads credits=NUM_LINE_BUFFERS and clears col, row and intr_cnt.
REQ-006 i_start outside IDLE SHALL be ignored.
REQ-007 o_s_ready SHALL equal (state==FEED) && (credits!=0), combinationally.
REQ-008 A transfer SHALL be i_s_valid && o_s_ready.
- On a transfer: o_pixel_data <= i_s_data and o_pixel_data_valid <= 1 on the next edge (latency 1).
- Otherwise o_pixel_data_valid <= 0 and o_pixel_data holds its value.
REQ-009 col SHALL increment on each transfer; when col==IMG_WIDTH-1 it wraps to 0, row increments and one credit is consumed.
REQ-010 On each i_intr pulse in FEED or DRAIN, intr_cnt SHALL increment and credits SHALL increment by 1.
REQ-011 When line-complete and i_intr occur in the same cycle, credits SHALL be unchanged.
REQ-012 If i_intr arrives with credits==NUM_LINE_BUFFERS and no simultaneous line-complete:
- credits saturates;
- o_err sets and stays set until reset.
REQ-013 i_intr in IDLE or DONE SHALL be ignored.
REQ-014 FEED -> DRAIN SHALL occur on the transfer that completes line IMG_HEIGHT-1.
REQ-015 DRAIN -> DONE SHALL occur when intr_cnt reaches IMG_HEIGHT-2, counting an i_intr in the current cycle.
REQ-016 In DONE, o_frame_done SHALL be 1 for exactly one cycle, followed by DONE -> IDLE on the next edge.
REQ-017 o_busy SHALL be 1 in FEED and DRAIN, and 0 in IDLE and DONE.
REQ-018 Counter widths SHALL be:
- col: clog2(IMG_WIDTH);
- row and intr_cnt: clog2(IMG_HEIGHT+1);
- credits: clog2(NUM_LINE_BUFFERS+1).
REQ-019 All counters SHALL be unsigned and SHALL never wrap except col as specified.
REQ-020 Upstream stalls (i_s_valid low) in FEED SHALL leave all counters unchanged.

Reset
REQ-021 Assertion of i_rst_n low SHALL immediately force:
- state=IDLE;
- o_pixel_data_valid, o_frame_done and o_err = 0;
- o_pixel_data = 0;
- col, row, intr_cnt and credits = 0.
REQ-022 Reset mid-frame SHALL abandon the frame with no o_frame_done; the downstream is reset by the same reset.
REQ-023 Release of reset SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-024 The shared package img_pkg SHALL hold:
- INTEGER_BITS, FIXED_POINT_BITS, IMG_WIDTH, IMG_HEIGHT and NUM_LINE_BUFFERS defaults;
- the pixel width constant;
- the FSM state encoding.
REQ-025 The credit bookkeeping (REQ-010 to REQ-012) SHALL be the single sub-module line_credit_counter; everything else SHALL stay flat.

Verification
REQ-026 The bench SHALL cover these scenarios (all except the first at IMG_WIDTH=8, IMG_HEIGHT=6):
- Reset: no start, i_s_valid=1 -> o_s_ready=0, o_pixel_data_valid=0, o_busy=0.
- Priming: start, continuous valid, no i_intr -> exactly 32 pixels forwarded, each 1 cycle later in order; o_s_ready drops after the 32nd.
- Credit return: after priming, one i_intr -> exactly 8 more pixels accepted, then o_s_ready=0.
- Full frame: 48 pixels plus 4 i_intr -> o_frame_done pulses once, 1 cycle after the 4th i_intr is counted; o_busy falls at that pulse.
- Collision and overflow: i_intr coincident with the line-complete beat -> credits unchanged. Extra i_intr at credits=4 -> o_err=1 and it stays set.
- Mid-frame reset: after 20 pixels -> outputs at reset values immediately; a new i_start re-primes 32 pixels.
